// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data/pixel memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
  } pix_burst_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int N  = 32,
  parameter int AW = 16
);
  logic          pipeReq;
  logic          pipeWrite;
  logic [AW-1:0] pipeAddr;
  logic [N-1:0]  pipeWD;
  logic          pipeStall;
  logic          pipeRValid;
  logic [N-1:0]  pipeRData;
  logic          pixReq;
  logic [AW-1:0] pixAddr;
  logic          pixGnt;
  logic          pixRValid;
  logic [N-1:0]  pixRData;
  logic          pixLast;
  logic          memWE;
  logic [AW-1:0] memAddr;
  logic [N-1:0]  memWD;
  logic [N-1:0]  memRD;

  modport slave (
    input  pipeReq, pipeWrite, pipeAddr, pipeWD, pixReq, pixAddr, memRD,
    output pipeStall, pipeRValid, pipeRData, pixGnt, pixRValid, pixRData, pixLast,
           memWE, memAddr, memWD
  );

  modport master (
    output pipeReq, pipeWrite, pipeAddr, pipeWD, pixReq, pixAddr, memRD,
    input  pipeStall, pipeRValid, pipeRData, pixGnt, pixRValid, pixRData, pixLast,
           memWE, memAddr, memWD
  );
endinterface

// File: rtl/mem_port_arbiter_age.sv
// Saturating starvation counter for a pending pixel request.
module arb_age_counter #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_cnt <= '0;
    else if (i_clr)                            r_cnt <= '0;
    else if (i_inc && r_cnt != CW'(MAX_WAIT))  r_cnt <= r_cnt + 1'b1;
  end

  assign o_sat = (r_cnt == CW'(MAX_WAIT));
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port arbiter: pipeline single-word accesses vs. pixel read bursts,
// with a starvation bound on the pixel side and one-cycle read return routing.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N         = 32,
  parameter int AW        = 16,
  parameter int BURST_LEN = 4,
  parameter int MAX_WAIT  = 8
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  arb_state_e     r_state, w_state_nxt;
  logic [BW-1:0]  r_beat, w_beat_nxt;
  pix_burst_req_t r_base, w_base_nxt;

  logic          w_sat, w_pipe_srv, w_gnt, w_beat_iss, w_last_iss;
  logic          w_we, w_stall;
  logic [AW-1:0] w_addr;
  logic [N-1:0]  w_wd;
  logic          r_pipe_rv, r_pix_rv, r_pix_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_beat  <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_base  <= w_base_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_base_nxt  = r_base;
    w_pipe_srv  = 1'b0;
    w_gnt       = 1'b0;
    w_beat_iss  = 1'b0;
    w_last_iss  = 1'b0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_wd        = '0;
    w_stall     = bus.pipeReq;
    case (r_state)
      ARB_IDLE: begin
        // A saturated pixel wait flips priority for exactly this cycle.
        if (bus.pipeReq && !(bus.pixReq && w_sat)) begin
          w_pipe_srv = 1'b1;
          w_stall    = 1'b0;
          w_addr     = bus.pipeAddr;
          w_we       = bus.pipeWrite;
          w_wd       = bus.pipeWD;
        end else if (bus.pixReq) begin
          w_gnt           = 1'b1;
          w_beat_iss      = 1'b1;
          w_addr          = bus.pixAddr;
          w_base_nxt.addr = bus.pixAddr;
          w_beat_nxt      = BW'(1);
          w_state_nxt     = ARB_BURST;
        end
      end
      ARB_BURST: begin
        w_beat_iss = 1'b1;
        w_addr     = r_base.addr + AW'(r_beat);
        if (r_beat == BW'(BURST_LEN - 1)) begin
          w_last_iss  = 1'b1;
          w_beat_nxt  = '0;
          w_state_nxt = ARB_IDLE;
        end else begin
          w_beat_nxt = r_beat + 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  arb_age_counter #(.MAX_WAIT(MAX_WAIT)) u_age (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (r_state == ARB_IDLE && bus.pixReq && !w_gnt),
    .i_clr (w_gnt || !bus.pixReq),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_rv  <= 1'b0;
      r_pix_rv   <= 1'b0;
      r_pix_last <= 1'b0;
    end else begin
      r_pipe_rv  <= w_pipe_srv && !bus.pipeWrite;
      r_pix_rv   <= w_beat_iss;
      r_pix_last <= w_last_iss;
    end
  end

  // Memory-side outputs are forced quiet while reset is held.
  assign bus.memWE      = rst_n & w_we;
  assign bus.memAddr    = rst_n ? w_addr : '0;
  assign bus.memWD      = rst_n ? w_wd : '0;
  assign bus.pixGnt     = rst_n & w_gnt;
  assign bus.pipeStall  = w_stall;
  assign bus.pipeRValid = r_pipe_rv;
  assign bus.pipeRData  = bus.memRD;
  assign bus.pixRValid  = r_pix_rv;
  assign bus.pixRData   = bus.memRD;
  assign bus.pixLast    = r_pix_last;
endmodule
